// File: rtl/sdram_init_seq_pkg.sv
// Shared definitions for the SDRAM power-up initialisation sequencer:
// command encodings, FSM state codes, default timing and mode-register layout.
package sdram_init_seq_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Gray-coded so adjacent states differ by one bit; codes are fixed because
  // external checkers decode them.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_PRE  = 3'b001,
    ST_TRP  = 3'b011,
    ST_AR   = 3'b010,
    ST_TRFC = 3'b110,
    ST_MRS  = 3'b111,
    ST_TMRD = 3'b101,
    ST_END  = 3'b100
  } state_t;

  // Default timing at 100 MHz
  localparam int unsigned T_POWER_DEF  = 20000;
  localparam int unsigned TRP_CLK_DEF  = 2;
  localparam int unsigned TRFC_CLK_DEF = 7;
  localparam int unsigned TMRD_CLK_DEF = 3;
  localparam int unsigned AR_TIMES_DEF = 8;

  localparam int WAIT_W = 15;
  localparam int REF_W  = 4;

  // Mode register fields:
  //   [2:0] burst length (3'b111 = full page)
  //   [3]   burst type   (0 = sequential)
  //   [6:4] CAS latency
  //   [8:7] operating mode (00 = standard)
  //   [9]   write burst mode (0 = burst write)
  //   [12:10] reserved, 0
  function automatic logic [12:0] mode_word(input logic [2:0] bl, input logic bt,
                                            input logic [2:0] cl, input logic wb);
    mode_word = {3'b000, wb, 2'b00, cl, bt, bl};
  endfunction

  localparam logic [12:0] MODE_REG_DEF = mode_word(3'b111, 1'b0, 3'd3, 1'b0); // 13'h037

endpackage

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation: wait, PRECHARGE ALL, N x AUTO REFRESH,
// LOAD MODE REGISTER, then hold NOP with init_end high until reset.
module sdram_init_seq
  import sdram_init_seq_pkg::*;
#(
  parameter int unsigned T_POWER  = T_POWER_DEF,
  parameter int unsigned TRP_CLK  = TRP_CLK_DEF,
  parameter int unsigned TRFC_CLK = TRFC_CLK_DEF,
  parameter int unsigned TMRD_CLK = TMRD_CLK_DEF,
  parameter int unsigned AR_TIMES = AR_TIMES_DEF,
  parameter logic [12:0] MODE_REG = MODE_REG_DEF
) (
  input  logic        init_clk,
  input  logic        init_rst_n,
  output logic [3:0]  init_cmd,
  output logic [1:0]  init_bank,
  output logic [12:0] init_addr,
  output logic        init_end
);

  state_t              state_curr, state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [REF_W-1:0]    ref_cnt;

  // Terminal counts of each wait state
  localparam logic [WAIT_W-1:0] POWER_LAST = WAIT_W'(T_POWER - 1);
  localparam logic [WAIT_W-1:0] TRP_LAST   = WAIT_W'(TRP_CLK - 1);
  localparam logic [WAIT_W-1:0] TRFC_LAST  = WAIT_W'(TRFC_CLK - 1);
  localparam logic [WAIT_W-1:0] TMRD_LAST  = WAIT_W'(TMRD_CLK - 1);
  localparam logic [REF_W-1:0]  AR_LAST    = REF_W'(AR_TIMES);

  // State register
  always_ff @(posedge init_clk) begin
    if (!init_rst_n) state_curr <= ST_IDLE;
    else             state_curr <= state_next;
  end

  // Next-state: command states last one cycle, wait states run to their terminal count
  always_comb begin
    state_next = state_curr;
    case (state_curr)
      ST_IDLE: if (wait_cnt == POWER_LAST) state_next = ST_PRE;
      ST_PRE:  state_next = ST_TRP;
      ST_TRP:  if (wait_cnt == TRP_LAST)   state_next = ST_AR;
      ST_AR:   state_next = ST_TRFC;
      ST_TRFC: if (wait_cnt == TRFC_LAST)
                 state_next = (ref_cnt == AR_LAST) ? ST_MRS : ST_AR;
      ST_MRS:  state_next = ST_TMRD;
      ST_TMRD: if (wait_cnt == TMRD_LAST)  state_next = ST_END;
      ST_END:  state_next = ST_END;
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait counter: zero on the first cycle of every state, frozen once done
  always_ff @(posedge init_clk) begin
    if (!init_rst_n)                  wait_cnt <= '0;
    else if (state_next != state_curr) wait_cnt <= '0;
    else if (state_curr != ST_END)     wait_cnt <= wait_cnt + 1'b1;
  end

  // Refresh counter: bumps as each AUTO REFRESH is entered
  always_ff @(posedge init_clk) begin
    if (!init_rst_n)                                    ref_cnt <= '0;
    else if (state_next == ST_AR && state_curr != ST_AR) ref_cnt <= ref_cnt + 1'b1;
  end

  // Moore output decode; A10=1 outside MRS makes PRECHARGE hit all banks
  always_comb begin
    init_cmd  = CMD_NOP;
    init_bank = 2'b11;
    init_addr = 13'h1FFF;
    case (state_curr)
      ST_PRE: init_cmd = CMD_PRE;
      ST_AR:  init_cmd = CMD_AR;
      ST_MRS: begin
        init_cmd  = CMD_LMR;
        init_bank = 2'b00;
        init_addr = MODE_REG;
      end
      default: ;
    endcase
  end

  assign init_end = (state_curr == ST_END);

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: timeline model derived from the timing rules,
// a table of fixed checkpoints, and randomized mid-sequence reset.
module tb_sdram_init_seq;

  localparam int T_POWER = 20000;
  localparam int TRP     = 2;
  localparam int TRFC    = 7;
  localparam int TMRD    = 3;
  localparam int NAR     = 8;

  localparam int T_PRE = T_POWER;
  localparam int T_AR0 = T_PRE + 1 + TRP;
  localparam int AR_PER = 1 + TRFC;
  localparam int T_MRS = T_AR0 + NAR * AR_PER;
  localparam int T_END = T_MRS + 1 + TMRD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd;
  logic [1:0]  bank;
  logic [12:0] addr;
  logic        fin;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        fin;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        fin;
  } vec_t;

  vec_t tbl[$];

  sdram_init_seq dut (
    .init_clk   (clk),
    .init_rst_n (rst_n),
    .init_cmd   (cmd),
    .init_bank  (bank),
    .init_addr  (addr),
    .init_end   (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Expected pins for cycle k after reset release, from the sequence timeline
  function automatic exp_t model(input int k);
    exp_t e;
    e = '{cmd: 4'b0111, bank: 2'b11, addr: 13'h1FFF, fin: 1'b0};
    if (k == T_PRE) e.cmd = 4'b0010;
    else if (k >= T_AR0 && k < T_MRS && ((k - T_AR0) % AR_PER) == 0) e.cmd = 4'b0001;
    else if (k == T_MRS) begin
      e.cmd = 4'b0000; e.bank = 2'b00; e.addr = 13'h037;
    end
    else if (k >= T_END) e.fin = 1'b1;
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"},   32'(cmd),  32'h7);
    chk({tag, "_bank"},  32'(bank), 32'h3);
    chk({tag, "_addr"},  32'(addr), 32'h1FFF);
    chk({tag, "_end"},   32'(fin),  32'h0);
    chk({tag, "_state"}, 32'(dut.state_curr), 32'h0);
  endtask

  // Hold reset for n edges, checking idle outputs after each; leaves rst_n low
  task automatic hold_reset(input int n, input string tag);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      chk_reset_vals(tag);
    end
  endtask

  // Called at a negedge with rst_n just released: checks cycles 0..ncyc-1
  task automatic run(input int ncyc, input bit use_tbl, output int n_ar);
    exp_t e;
    n_ar = 0;
    for (int k = 0; k < ncyc; k++) begin
      e = model(k);
      chk("cmd",  32'(cmd),  32'(e.cmd));
      chk("bank", 32'(bank), 32'(e.bank));
      chk("addr", 32'(addr), 32'(e.addr));
      chk("end",  32'(fin),  32'(e.fin));
      if (k >= T_END) chk("end_state", 32'(dut.state_curr), 32'h4);
      if (use_tbl) begin
        foreach (tbl[i]) if (tbl[i].cyc == k) begin
          chk("tbl_cmd",  32'(cmd),  32'(tbl[i].cmd));
          chk("tbl_bank", 32'(bank), 32'(tbl[i].bank));
          chk("tbl_addr", 32'(addr), 32'(tbl[i].addr));
          chk("tbl_end",  32'(fin),  32'(tbl[i].fin));
        end
      end
      if (cmd == 4'b0001) n_ar++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    int n_ar;
    int r_cyc;
    int r_len;

    // Fixed checkpoints along the default timeline
    tbl.push_back('{0,     4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{19999, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20000, 4'b0010, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20001, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20002, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20003, 4'b0001, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20010, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20011, 4'b0001, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20059, 4'b0001, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20066, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20067, 4'b0000, 2'b00, 13'h0037, 1'b0});
    tbl.push_back('{20070, 4'b0111, 2'b11, 13'h1FFF, 1'b0});
    tbl.push_back('{20071, 4'b0111, 2'b11, 13'h1FFF, 1'b1});
    tbl.push_back('{21070, 4'b0111, 2'b11, 13'h1FFF, 1'b1});

    // Power-on reset, full sequence, then 1000 cycles parked in END
    rst_n = 1'b0;
    @(negedge clk);
    hold_reset(10, "por");
    rst_n = 1'b1;
    run(T_END + 1000, 1'b1, n_ar);
    chk("ar_count", 32'(n_ar), 32'(NAR));

    // Reset from END: init_end drops on the next edge
    hold_reset(1, "rst_from_end");

    // Restart, then reset somewhere in the refresh train
    rst_n = 1'b1;
    r_cyc = int'($urandom_range(20035, 20025));
    r_len = int'($urandom_range(4, 1));
    run(r_cyc, 1'b0, n_ar);
    hold_reset(r_len, "rst_mid");

    // Full T_POWER wait again, PRE back at 20000, complete sequence
    rst_n = 1'b1;
    run(T_END + 5, 1'b0, n_ar);
    chk("ar_count_restart", 32'(n_ar), 32'(NAR));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
